// File: rtl/hazard_stall_ctrl_if.sv
// Hazard bundle between the MIPS datapath (master) and the stall controller (slave).
// Carries ID decode fields, the EX branch outcome, the dmem handshake and all stage controls.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_memread;
    logic [4:0]       id_dst;
    logic             id_j;
    logic             id_jr;
    logic             ex_br_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_valid,
        output id_rs,
        output id_rt,
        output id_uses_rs,
        output id_uses_rt,
        output id_memread,
        output id_dst,
        output id_j,
        output id_jr,
        output ex_br_taken,
        output dmem_req,
        output dmem_ready,
        input  pc_write,
        input  ifid_write,
        input  ifid_flush,
        input  idex_write,
        input  idex_flush,
        input  exmem_write,
        input  memwb_flush,
        input  stall_cnt,
        input  flush_cnt,
        input  mem_timeout
    );

    modport slave (
        input  id_valid,
        input  id_rs,
        input  id_rt,
        input  id_uses_rs,
        input  id_uses_rt,
        input  id_memread,
        input  id_dst,
        input  id_j,
        input  id_jr,
        input  ex_br_taken,
        input  dmem_req,
        input  dmem_ready,
        output pc_write,
        output ifid_write,
        output ifid_flush,
        output idex_write,
        output idex_flush,
        output exmem_write,
        output memwb_flush,
        output stall_cnt,
        output flush_cnt,
        output mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use bubbles, jump/branch
// squashes, data-memory freezes, plus saturating stall/flush perf counters.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
    localparam logic [16:0]      LP_TO      = 17'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_ex_load;
    logic [4:0]       r_ex_dst;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [15:0]      r_wait_cnt;
    logic             r_timeout;

    logic             w_memwait;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_load_use;
    logic             w_jump;
    logic             w_branch;

    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_write;
    logic             w_idex_flush;
    logic             w_exmem_write;
    logic             w_memwb_flush;

    logic [16:0]      w_wait_inc;
    logic [15:0]      w_wait_nxt;
    logic             w_timeout_hit;

    // Hazard detection against the shadow copy of the instruction now in EX.
    assign w_memwait  = bus.dmem_req & ~bus.dmem_ready;
    assign w_branch   = bus.ex_br_taken;
    assign w_rs_hit   = bus.id_uses_rs & (bus.id_rs == r_ex_dst);
    assign w_rt_hit   = bus.id_uses_rt & (bus.id_rt == r_ex_dst);
    assign w_load_use = bus.id_valid & r_ex_load & (r_ex_dst != 5'd0)
                      & (w_rs_hit | w_rt_hit);
    assign w_jump     = bus.id_valid & (bus.id_j | bus.id_jr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_write  = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_write = 1'b1;
        w_memwb_flush = 1'b0;

        unique case (r_state)
            S_RUN: begin
                if (w_memwait) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_memwait) begin
                    w_state_nxt = S_RUN;
                end
            end
        endcase

        // A freeze hides every other hazard; they are re-seen once memory is ready.
        if (w_memwait) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_flush = 1'b1;
        end else if (w_branch) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
        end else if (w_jump) begin
            w_ifid_flush  = 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign bus.pc_write    = rst_n & w_pc_write;
    assign bus.ifid_write  = rst_n & w_ifid_write;
    assign bus.ifid_flush  = rst_n & w_ifid_flush;
    assign bus.idex_write  = rst_n & w_idex_write;
    assign bus.idex_flush  = rst_n & w_idex_flush;
    assign bus.exmem_write = rst_n & w_exmem_write;
    assign bus.memwb_flush = rst_n & w_memwb_flush;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
    assign bus.mem_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_load <= 1'b0;
            r_ex_dst  <= 5'd0;
        end else if (w_idex_write) begin
            r_ex_load <= bus.id_valid & bus.id_memread & ~w_idex_flush;
            r_ex_dst  <= bus.id_dst;
        end
    end

    // Consecutive freeze cycles, clamped so a long wait cannot wrap.
    assign w_wait_inc    = {1'b0, r_wait_cnt} + 17'd1;
    assign w_timeout_hit = w_memwait & (w_wait_inc >= LP_TO);

    always_comb begin
        w_wait_nxt = 16'd0;
        if (w_memwait) begin
            if (w_wait_inc >= LP_TO) begin
                w_wait_nxt = LP_TO[15:0];
            end else begin
                w_wait_nxt = w_wait_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != LP_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ifid_flush && (r_flush_cnt != LP_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven scoreboard bench for hazard_stall_ctrl (CNT_W=4, MEM_TIMEOUT=4).
// Counters are checked against running sums of the expected control vectors.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
    localparam logic [6:0] C_RUN  = 7'b1101010;
    localparam logic [6:0] C_WAIT = 7'b0000001;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_JMP  = 7'b1111010;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       mr;
        logic [4:0] dst;
        logic       j;
        logic       jr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] ctl;
        logic       to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic urs,
        input logic [4:0] rt, input logic urt, input logic mr,
        input logic [4:0] dst, input logic j, input logic jr,
        input logic br, input logic req, input logic rdy,
        input logic [6:0] ctl, input logic to
    );
        vec_t t;
        t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
        t.mr = mr; t.dst = dst; t.j = j; t.jr = jr; t.br = br;
        t.req = req; t.rdy = rdy; t.ctl = ctl; t.to = to;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_rs       = t.rs;
        bus.id_uses_rs  = t.urs;
        bus.id_rt       = t.rt;
        bus.id_uses_rt  = t.urt;
        bus.id_memread  = t.mr;
        bus.id_dst      = t.dst;
        bus.id_j        = t.j;
        bus.id_jr       = t.jr;
        bus.ex_br_taken = t.br;
        bus.dmem_req    = t.req;
        bus.dmem_ready  = t.rdy;
    endtask

    function automatic logic [6:0] got_ctl();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_write, bus.idex_flush, bus.exmem_write,
                bus.memwb_flush};
    endfunction

    task automatic check_cycle();
        vec_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        chk("ctl", 32'(got_ctl()), 32'(e.ctl));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        chk("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
        if (!e.ctl[6] && m_stall < CMAX) m_stall++;
        if (e.ctl[4] && m_flush < CMAX) m_flush++;
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        drive(t);
        sb.push_back(t);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, 32'(got_ctl()), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'd0);
        chk({tag, "_flush"}, 32'(bus.flush_cnt), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.mem_timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        vec_t lw;
        vec_t use8;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);
        lw   = mk(1, 29, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, C_RUN, 0);
        use8 = mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 0, 0, 0, C_RUN, 0);

        // load-use, $0 and no-use cases
        vecs.push_back(lw);
        vecs.push_back(mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 0, 0, 0, C_LU, 0));
        vecs.push_back(use8);
        vecs.push_back(lw);
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 9, 0, 0, 0, 0, 0, C_RUN, 0));
        vecs.push_back(lw);
        vecs.push_back(mk(1, 8, 0, 8, 0, 0, 8, 0, 0, 0, 0, 0, C_RUN, 0));
        vecs.push_back(mk(1, 29, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 9, 0, 0, 0, 0, 0, C_RUN, 0));
        vecs.push_back(lw);
        vecs.push_back(mk(0, 0, 0, 8, 1, 0, 9, 0, 0, 0, 0, 0, C_RUN, 0));
        // branch beats load-use and clears the shadow
        vecs.push_back(lw);
        vecs.push_back(mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 1, 0, 0, C_BR, 0));
        vecs.push_back(use8);
        // jumps
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_JMP, 0));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_JMP, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN, 0));
        // three-cycle memory wait then ready
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_WAIT, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0));
        // jump under a freeze fires on the ready cycle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_WAIT, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, C_JMP, 0));
        // load-use under a freeze: shadow held, bubble on ready
        vecs.push_back(lw);
        vecs.push_back(mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 0, 1, 0, C_WAIT, 0));
        vecs.push_back(mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 0, 1, 1, C_LU, 0));
        vecs.push_back(use8);
        // branch under a freeze
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_WAIT, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR, 0));
        // load-use beats a JR reading the load target
        vecs.push_back(lw);
        vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_LU, 0));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_JMP, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0));
        // five-cycle wait: timeout visible from the fifth cycle on
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_WAIT,
                              (i == 4) ? 1'b1 : 1'b0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1));
        // drive both counters into saturation
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_WAIT, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_JMP, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1));

        // outputs stay quiet in reset even with every hazard asserted
        drive(mk(1, 8, 1, 8, 1, 1, 8, 1, 1, 1, 1, 0, C_RUN, 0));
        #3;
        check_reset("rst");
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset in the middle of a wait
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_WAIT, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_WAIT, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        m_stall = 0;
        m_flush = 0;
        drive(idle);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(idle);
        apply(lw);
        apply(mk(1, 8, 1, 9, 1, 0, 10, 0, 0, 0, 0, 0, C_LU, 0));
        apply(use8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
